// File: rtl/pll_lock_reset_seq.sv
// rtl/pll_lock_reset_seq.sv - PLL lock qualification and system reset sequencer
//
// Brings the raw PLL lock flag into the PLL output clock domain, requires it to
// stay high for STABLE_CYCLES, then holds sys_reset for HOLD_CYCLES more before
// entering RUN. A lock drop while in RUN re-asserts sys_reset and is recorded.
//
// Ports:
//   clock       PLL output clock, all logic on rising edge
//   reset       synchronous active-high reset
//   locked_in   raw PLL lock flag, asynchronous to clock
//   clear_lost  single-cycle pulse, clears lock_lost and lost_count
//   sys_reset   synchronous active-high reset for downstream logic
//   ready       high only while in RUN
//   lock_lost   sticky flag, lock dropped at least once while in RUN
//   lost_count  saturating count of RUN-state lock losses
//   state       debug: 0 WAIT, 1 STABLE, 2 HOLD, 3 RUN
module pll_lock_reset_seq #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             locked_in,
  input  logic             clear_lost,
  output logic             sys_reset,
  output logic             ready,
  output logic             lock_lost,
  output logic [CNT_W-1:0] lost_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_STABLE = 2'd1,
    ST_HOLD   = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  localparam int MAX_CYCLES = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;

  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   sys_reset_q, sys_reset_d;
  logic                   ready_q, ready_d;
  logic                   lock_lost_q, lock_lost_d;
  logic [CNT_W-1:0]       lost_count_q, lost_count_d;
  logic                   locked_s;
  logic                   loss;

  // Only the last synchroniser stage is ever looked at by the FSM.
  assign locked_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], locked_in};
    state_d      = state_q;
    cnt_d        = cnt_q;
    loss         = 1'b0;
    lock_lost_d  = lock_lost_q;
    lost_count_d = lost_count_q;

    case (state_q)
      ST_WAIT: begin
        if (locked_s) state_d = ST_STABLE;
      end
      ST_STABLE: begin
        if (!locked_s)                state_d = ST_WAIT;
        else if (cnt_q == STABLE_LAST) state_d = ST_HOLD;
        else                          cnt_d   = cnt_q + CW'(1);
      end
      ST_HOLD: begin
        // Dropping out of HOLD is a failed qualification, not a counted loss.
        if (!locked_s)              state_d = ST_WAIT;
        else if (cnt_q == HOLD_LAST) state_d = ST_RUN;
        else                        cnt_d   = cnt_q + CW'(1);
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_WAIT;
          loss    = 1'b1;
        end
      end
      default: state_d = ST_WAIT;
    endcase

    // Every state starts its dwell count from zero.
    if (state_d != state_q) cnt_d = '0;

    if (clear_lost) begin
      lock_lost_d  = 1'b0;
      lost_count_d = '0;
    end

    // A loss on the same edge as a clear wins and becomes the first new event.
    if (loss) begin
      lock_lost_d = 1'b1;
      if (clear_lost)         lost_count_d = CNT_W'(1);
      else if (&lost_count_q) lost_count_d = lost_count_q;
      else                    lost_count_d = lost_count_q + CNT_W'(1);
    end

    // Outputs follow next-state so they move on the same edge as state.
    sys_reset_d = (state_d != ST_RUN);
    ready_d     = (state_d == ST_RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q       <= '0;
      state_q      <= ST_WAIT;
      cnt_q        <= '0;
      sys_reset_q  <= 1'b1;
      ready_q      <= 1'b0;
      lock_lost_q  <= 1'b0;
      lost_count_q <= '0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sys_reset_q  <= sys_reset_d;
      ready_q      <= ready_d;
      lock_lost_q  <= lock_lost_d;
      lost_count_q <= lost_count_d;
    end
  end

  assign sys_reset  = sys_reset_q;
  assign ready      = ready_q;
  assign lock_lost  = lock_lost_q;
  assign lost_count = lost_count_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// tb/tb_pll_lock_reset_seq.sv - directed scoreboard bench for pll_lock_reset_seq
module tb_pll_lock_reset_seq;

  logic       clock = 1'b0;
  logic       reset;
  logic       locked_in;
  logic       clear_lost;
  logic       sys_reset;
  logic       ready;
  logic       lock_lost;
  logic [1:0] lost_count;
  logic [1:0] state;

  pll_lock_reset_seq #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (8),
    .HOLD_CYCLES   (4),
    .CNT_W         (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .locked_in  (locked_in),
    .clear_lost (clear_lost),
    .sys_reset  (sys_reset),
    .ready      (ready),
    .lock_lost  (lock_lost),
    .lost_count (lost_count),
    .state      (state)
  );

  always #5 clock = ~clock;

  // Edge counter: value k is visible after the k-th rising edge.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Packed view {state, sys_reset, ready, lock_lost, lost_count}.
  typedef struct {
    string      tag;
    int         at;
    logic [6:0] exp;
  } sb_t;

  sb_t sb[$];
  int  compared   = 0;
  int  mismatched = 0;

  function automatic logic [6:0] v_rst();
    return {2'd0, 1'b1, 1'b0, 1'b0, 2'd0};
  endfunction

  function automatic logic [6:0] v_nr(input logic [1:0] st, input logic ll, input logic [1:0] lc);
    return {st, 1'b1, 1'b0, ll, lc};
  endfunction

  function automatic logic [6:0] v_run(input logic ll, input logic [1:0] lc);
    return {2'd3, 1'b0, 1'b1, ll, lc};
  endfunction

  task automatic push(input string tag, input int at, input logic [6:0] exp);
    sb_t e;
    e.tag = tag;
    e.at  = at;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Compare scheduled expectations away from the active edge.
  always @(negedge clock) begin
    logic [6:0] obs;
    obs = {state, sys_reset, ready, lock_lost, lost_count};
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        compared++;
        assert (sb[i].at == cyc && obs === sb[i].exp)
        else begin
          mismatched++;
          $error("FAIL %s: observed %h expected %h at edge %0d (now %0d)",
                 sb[i].tag, obs, sb[i].exp, sb[i].at, cyc);
        end
        sb.delete(i);
      end
    end
  end

  // One RUN-state lock loss followed by requalification back to RUN.
  task automatic loss(input string tag, input logic ll_prev, input logic [1:0] lc_prev,
                      input logic [1:0] lc_new, input bit clr);
    int c;
    c = cyc;
    push({tag, "_pre"},  c + 2,  v_run(ll_prev, lc_prev));
    push({tag, "_drop"}, c + 3,  v_nr(2'd0, 1'b1, lc_new));
    push({tag, "_hold"}, c + 17, v_nr(2'd2, 1'b1, lc_new));
    push({tag, "_run"},  c + 18, v_run(1'b1, lc_new));
    locked_in = 1'b0;
    wait_until(c + 2);
    if (clr) clear_lost = 1'b1;
    wait_until(c + 3);
    clear_lost = 1'b0;
    locked_in  = 1'b1;
    wait_until(c + 18);
  endtask

  initial begin
    int c;
    reset      = 1'b1;
    locked_in  = 1'b1;
    clear_lost = 1'b0;

    // Power-up: reset for 3 edges, lock first sampled at edge 4.
    push("rst_e1", 1, v_rst());
    push("rst_e3", 3, v_rst());
    push("pu_wait", 5, v_rst());
    push("pu_stable", 6, v_nr(2'd1, 1'b0, 2'd0));
    push("pu_stable_last", 13, v_nr(2'd1, 1'b0, 2'd0));
    push("pu_hold", 14, v_nr(2'd2, 1'b0, 2'd0));
    push("pu_hold_last", 17, v_nr(2'd2, 1'b0, 2'd0));
    push("pu_run", 18, v_run(1'b0, 2'd0));
    wait_until(3);
    reset = 1'b0;
    wait_until(18);

    // Reset in RUN, then glitch during STABLE at counter 5.
    c = cyc;
    push("rst_run0", c + 1, v_rst());
    reset = 1'b1;
    wait_until(c + 1);
    reset = 1'b0;
    c = cyc;
    push("gl_stable", c + 3, v_nr(2'd1, 1'b0, 2'd0));
    push("gl_cnt5", c + 8, v_nr(2'd1, 1'b0, 2'd0));
    push("gl_wait", c + 9, v_rst());
    push("gl_restable", c + 10, v_nr(2'd1, 1'b0, 2'd0));
    push("gl_hold", c + 18, v_nr(2'd2, 1'b0, 2'd0));
    push("gl_hold_last", c + 21, v_nr(2'd2, 1'b0, 2'd0));
    push("gl_run", c + 22, v_run(1'b0, 2'd0));
    wait_until(c + 6);
    locked_in = 1'b0;
    wait_until(c + 7);
    locked_in = 1'b1;
    wait_until(c + 22);

    // RUN losses: first loss, then saturation 2, 3, 3, 3.
    loss("loss1", 1'b0, 2'd0, 2'd1, 1'b0);
    loss("loss2", 1'b1, 2'd1, 2'd2, 1'b0);
    loss("loss3", 1'b1, 2'd2, 2'd3, 1'b0);
    loss("loss4", 1'b1, 2'd3, 2'd3, 1'b0);
    loss("loss5", 1'b1, 2'd3, 2'd3, 1'b0);

    // clear_lost on the same edge as a loss: loss wins.
    loss("clr_loss", 1'b1, 2'd3, 2'd1, 1'b1);

    // Lone clear in RUN.
    c = cyc;
    push("clr_lone", c + 1, v_run(1'b0, 2'd0));
    push("clr_after", c + 2, v_run(1'b0, 2'd0));
    clear_lost = 1'b1;
    wait_until(c + 1);
    clear_lost = 1'b0;
    wait_until(c + 2);

    // Reset in HOLD with lost_count = 2.
    loss("r6a", 1'b0, 2'd0, 2'd1, 1'b0);
    c = cyc;
    push("r6_drop", c + 3, v_nr(2'd0, 1'b1, 2'd2));
    push("r6_hold", c + 14, v_nr(2'd2, 1'b1, 2'd2));
    push("r6_rst_hold", c + 15, v_rst());
    push("r6_run", c + 30, v_run(1'b0, 2'd0));
    locked_in = 1'b0;
    wait_until(c + 3);
    locked_in = 1'b1;
    wait_until(c + 14);
    reset = 1'b1;
    wait_until(c + 15);
    reset = 1'b0;
    wait_until(c + 30);

    // Reset in RUN with lost_count = 2.
    loss("r6b", 1'b0, 2'd0, 2'd1, 1'b0);
    loss("r6c", 1'b1, 2'd1, 2'd2, 1'b0);
    c = cyc;
    push("r6_rst_run", c + 1, v_rst());
    push("r6_rst_after", c + 2, v_rst());
    reset = 1'b1;
    wait_until(c + 1);
    reset = 1'b0;
    wait_until(c + 4);

    compared++;
    assert (sb.size() == 0)
    else begin
      mismatched++;
      $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed edge %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pll_lock_reset_seq.md
Name: pll_lock_reset_seq

Overview:
Consumer side of the PLL lock interface. Takes the PLL `locked` indication into the PLL output clock domain, qualifies it, and generates the design's synchronous system reset and ready flag. Detects loss of lock after run-up, re-asserts system reset, and records loss events for debug/LED status. Sits directly after the PLL wrapper, ahead of the video timing and game logic.

Parameters:
SYNC_STAGES, 2, synchroniser flop count on locked_in (>=2)
STABLE_CYCLES, 1024, consecutive synchronised-locked cycles required before reset hold begins (>=1)
HOLD_CYCLES, 16, additional cycles sys_reset stays high after lock qualified (>=1)
CNT_W, 8, width of lost_count

Ports:
clock  input  1  PLL output clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
locked_in  input  1  raw PLL lock flag; treated as asynchronous
clear_lost  input  1  single-cycle pulse; clears lock_lost and lost_count
sys_reset  output  1  synchronous active-high reset for downstream logic
ready  output  1  high only while in RUN
lock_lost  output  1  sticky: lock dropped at least once while in RUN
lost_count  output  CNT_W  saturating count of RUN-state lock losses
state  output  2  debug: 0 WAIT, 1 STABLE, 2 HOLD, 3 RUN

Behaviour:
- One clock, synchronous active-high reset.
- On reset (wins over everything):
  - sync chain = 0, state = WAIT, counter = 0
  - sys_reset = 1, ready = 0, lock_lost = 0, lost_count = 0
- Synchroniser: locked_s is locked_in delayed through SYNC_STAGES flops. No other logic reads locked_in.
- Counter width is clog2(max(STABLE_CYCLES, HOLD_CYCLES)) + 1. The counter resets to 0 on every state change.
- FSM (transitions on rising edge):
  - WAIT: if locked_s = 1, go to STABLE.
  - STABLE: if locked_s = 0, go to WAIT. Otherwise, if counter == STABLE_CYCLES-1, go to HOLD; else counter++. STABLE therefore occupies exactly STABLE_CYCLES cycles.
  - HOLD: if locked_s = 0, go to WAIT (not a counted loss). Otherwise, if counter == HOLD_CYCLES-1, go to RUN; else counter++.
  - RUN: if locked_s = 0, go to WAIT and record a loss event.
- Outputs are registered from next-state, so they change on the same edge as state:
  - sys_reset = 1 in every state except RUN.
  - ready = 1 only in RUN.
- Latency: locked_in first sampled high at edge j and held steady gives state = STABLE after edge j+SYNC_STAGES, and sys_reset = 0 / ready = 1 after edge j+SYNC_STAGES+STABLE_CYCLES+HOLD_CYCLES.
- Lock drop in RUN:
  - locked_in low first sampled at edge m gives sys_reset = 1 / ready = 0 after edge m+SYNC_STAGES.
  - The same edge sets lock_lost = 1 and increments lost_count, saturating at 2^CNT_W-1.
- Glitch filtering: a low locked_s for a single cycle during STABLE or HOLD restarts qualification from WAIT. The full STABLE_CYCLES + HOLD_CYCLES is required again.
- clear_lost:
  - On the next edge, lock_lost = 0 and lost_count = 0.
  - If a loss event occurs on the same edge, the loss wins: lock_lost = 1, lost_count = 1.
  - clear_lost has no effect on state, sys_reset or ready.
- Reset mid-operation (any state): immediate return to reset values on that edge, including clearing lock_lost and lost_count.
- locked_in stuck low: the FSM stays in WAIT indefinitely with sys_reset = 1. There is no timeout.

Test Plan (SYNC_STAGES=2, STABLE_CYCLES=8, HOLD_CYCLES=4, CNT_W=2):
1. Power-up: reset high 3 cycles with locked_in = 1, then release; locked_in first sampled at edge j → state 1 after j+2, state 2 after j+10, sys_reset 1→0 and ready 0→1 after j+14.
2. Glitch in STABLE: locked_in low for 1 cycle at STABLE counter = 5 → state returns to 0; ready rises 14 edges after locked_in is resampled high; lock_lost stays 0.
3. Lock loss in RUN: drop locked_in at edge m → sys_reset = 1, ready = 0, lock_lost = 1, lost_count = 1 after m+2; restore lock → ready again after a further 14 edges.
4. Saturation: 5 RUN losses → lost_count sequence 1, 2, 3, 3, 3; lock_lost stays 1.
5. clear_lost coincident with a RUN loss edge → lost_count = 1, lock_lost = 1. A lone clear_lost pulse in RUN → lost_count = 0, lock_lost = 0, ready stays 1.
6. Reset asserted in HOLD and again in RUN with lost_count = 2 → next edge: state 0, sys_reset 1, ready 0, lost_count 0, lock_lost 0.
